// File: rtl/overture_seq_pkg.sv
// Shared types and encodings for the Overture fetch/execute sequencer.
// The class field is ir[7:6]; copy operands are ir[5:3] (src) and ir[2:0] (dst).
package overture_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_IMM  = 2'd0,
    CLS_CALC = 2'd1,
    CLS_COPY = 2'd2,
    CLS_COND = 2'd3
  } cls_t;

  localparam logic [2:0] IO_REG       = 3'd6;
  localparam logic [2:0] RF_DST_IMM   = 3'd0;
  localparam logic [2:0] RF_DST_CALC  = 3'd3;

  localparam logic [1:0] RF_MUX_IMM   = 2'd0;
  localparam logic [1:0] RF_MUX_ALU   = 2'd1;
  localparam logic [1:0] RF_MUX_COPY  = 2'd2;

  // Condition codes: bit0 = zero term, bit1 = negative term, bit2 = invert.
  localparam logic [2:0] COND_NEVER   = 3'd0;
  localparam logic [2:0] COND_EQ      = 3'd1;
  localparam logic [2:0] COND_LT      = 3'd2;
  localparam logic [2:0] COND_LE      = 3'd3;
  localparam logic [2:0] COND_ALWAYS  = 3'd4;
  localparam logic [2:0] COND_NE      = 3'd5;
  localparam logic [2:0] COND_GE      = 3'd6;
  localparam logic [2:0] COND_GT      = 3'd7;

  function automatic cls_t decode_cls(input logic [7:0] ir);
    return cls_t'(ir[7:6]);
  endfunction

endpackage

// File: rtl/overture_cond_eval.sv
// Condition evaluator shared in encoding with the core's condition unit:
// zero and sign tests on an 8-bit two's complement value, optionally inverted.
module overture_cond_eval (
  input  logic [2:0] cond,
  input  logic [7:0] val,
  output logic       taken
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (val == 8'h00);
  assign is_neg  = val[7];
  assign taken   = cond[2] ^ ((cond[0] & is_zero) | (cond[1] & is_neg));

endmodule

// File: rtl/overture_seq.sv
// Fetch/execute sequencer for the 8-bit Overture core: owns the PC and IR,
// fetches over a req/ack port and drives register-file, ALU and I/O handshakes.
module overture_seq
  import overture_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic [7:0] reg0_val,
  input  logic [7:0] reg3_val,
  output logic [2:0] rf_src,
  output logic [2:0] rf_dst,
  output logic       rf_wr_en,
  output logic [1:0] rf_mux,
  output logic [7:0] imm_data,
  output logic [2:0] alu_op,
  input  logic       io_in_valid,
  output logic       io_in_ready,
  output logic       io_out_valid,
  input  logic       io_out_ready,
  output logic       retired,
  output logic       idle
);

  state_t     state_reg;
  logic [7:0] pc_reg;
  logic [7:0] ir_reg;

  cls_t       cls;
  logic [2:0] copy_src;
  logic [2:0] copy_dst;
  logic       in_exec;
  logic       need_in;
  logic       need_out;
  logic       can_retire;
  logic       cond_hit;
  logic       taken;
  logic [7:0] pc_next;

  assign cls      = decode_cls(ir_reg);
  assign copy_src = ir_reg[5:3];
  assign copy_dst = ir_reg[2:0];
  assign in_exec  = (state_reg == ST_EXEC);

  // Only copies touching register 6 wait on the I/O port; everything else
  // retires in its single EXEC cycle.
  assign need_in    = (cls == CLS_COPY) && (copy_src == IO_REG);
  assign need_out   = (cls == CLS_COPY) && (copy_dst == IO_REG);
  assign can_retire = (!need_in || io_in_valid) && (!need_out || io_out_ready);

  overture_cond_eval u_cond_eval (
    .cond  (ir_reg[2:0]),
    .val   (reg3_val),
    .taken (cond_hit)
  );

  assign taken   = (cls == CLS_COND) && cond_hit;
  assign pc_next = taken ? reg0_val : pc_reg + 8'd1;

  assign imem_req  = (state_reg == ST_FETCH);
  assign imem_addr = pc_reg;
  assign idle      = (state_reg == ST_IDLE);
  assign retired   = in_exec && can_retire;

  always_comb begin
    rf_src       = 3'd0;
    rf_dst       = 3'd0;
    rf_mux       = RF_MUX_IMM;
    rf_wr_en     = 1'b0;
    imm_data     = 8'h00;
    alu_op       = 3'd0;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    if (in_exec) begin
      case (cls)
        CLS_IMM: begin
          rf_dst   = RF_DST_IMM;
          rf_mux   = RF_MUX_IMM;
          imm_data = {2'b00, ir_reg[5:0]};
          rf_wr_en = 1'b1;
        end
        CLS_CALC: begin
          rf_dst   = RF_DST_CALC;
          rf_mux   = RF_MUX_ALU;
          alu_op   = ir_reg[2:0];
          rf_wr_en = 1'b1;
        end
        CLS_COPY: begin
          rf_src       = copy_src;
          rf_dst       = copy_dst;
          rf_mux       = RF_MUX_COPY;
          // Each side offers its handshake only once the other side can finish,
          // so a 6->6 copy completes both transfers in the same cycle.
          io_in_ready  = need_in && (!need_out || io_out_ready);
          io_out_valid = need_out && (!need_in || io_in_valid);
          rf_wr_en     = can_retire && (copy_dst < IO_REG);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // A fetch in flight always completes; run is only looked at on retire.
          if (imem_ack) begin
            ir_reg    <= imem_data;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (can_retire) begin
            pc_reg    <= pc_next;
            state_reg <= run ? ST_FETCH : ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/overture_seq.md
Name: overture_seq

Overview:
- Multi-cycle fetch/execute sequencer for the 8-bit Overture core.
- Fetches instructions over a req/ack program-memory port and decodes the 2-bit class.
- Drives register-file/ALU control and handshakes the I/O port (register 6).
- Resolves conditional jumps with an internal condition evaluator (same condition encoding as the core's condition unit) and owns the PC.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = execute; 0 = stop at the next instruction boundary.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  8  fetch address (= PC).
- imem_ack  in  1  data valid; completes the fetch.
- imem_data  in  8  instruction byte.
- reg0_val  in  8  current register 0 (jump target).
- reg3_val  in  8  current register 3 (condition input).
- rf_src  out  3  copy source select.
- rf_dst  out  3  write destination select.
- rf_wr_en  out  1  register-file write strobe, one cycle.
- rf_mux  out  2  write data source: 0 = imm, 1 = ALU, 2 = copy source.
- imm_data  out  8  zero-extended IR[5:0].
- alu_op  out  3  IR[2:0].
- io_in_valid  in  1  input port has data.
- io_in_ready  out  1  sequencer consumes input.
- io_out_valid  out  1  sequencer presents output.
- io_out_ready  in  1  output port accepts.
- retired  out  1  one-cycle pulse per completed instruction.
- idle  out  1  1 in IDLE state.

Behaviour:
- States: IDLE, FETCH, EXEC.
- Reset: state = IDLE, pc = RESET_PC, ir = 0. All strobes and handshake outputs are 0; idle = 1.
- IDLE → FETCH when run = 1.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: ir <= imem_data, go to EXEC.
  - imem_ack while not in FETCH is ignored.
  - A fetch is never abandoned: run is not sampled in FETCH.
- EXEC decode, using ir[7:6]:
  - 00 (immediate): rf_dst = 0, rf_mux = 0. Retires in 1 cycle.
  - 01 (calculate): rf_dst = 3, rf_mux = 1, alu_op = ir[2:0]. Retires in 1 cycle.
  - 10 (copy): rf_src = ir[5:3], rf_dst = ir[2:0], rf_mux = 2.
    - need_in = (src == 6); need_out = (dst == 6).
    - Retire when (!need_in | io_in_valid) & (!need_out | io_out_ready). Stall otherwise.
    - io_in_ready = EXEC & need_in & (!need_out | io_out_ready).
    - io_out_valid = EXEC & need_out & (!need_in | io_in_valid).
    - No register write for dst 6 or dst 7. Src 7 is passed through unchanged.
  - 11 (condition): taken = c[2] ^ ((c[0] & reg3_val == 0) | (c[1] & reg3_val[7])), with c = ir[2:0].
    - Codes: 0 never, 1 =0, 2 <0, 3 ≤0, 4 always, 5 ≠0, 6 ≥0, 7 >0 (two's complement).
    - No register write.
- rf_wr_en = 1 only in the retire cycle of classes 00 and 01, and of class 10 with dst ≤ 5.
- Control selects are valid only in EXEC; they are 0 elsewhere.
- Retire edge:
  - pc <= taken ? reg0_val : pc + 1, modulo 256 (0xFF wraps to 0x00).
  - retired pulses for one cycle.
  - Next state = run ? FETCH : IDLE.
- Latency: fetch takes ack latency + 1 cycle. Non-stalled EXEC takes 1 cycle. Minimum is 2 cycles per instruction with same-cycle ack.
- Reset asserted mid-fetch or mid-stall returns to reset values immediately. No partial writes or handshakes are emitted.
- reg0_val and reg3_val are sampled combinationally in the retire cycle.

Decomposition:
- Package overture_seq_pkg:
  - State enum.
  - Class codes CLS_IMM, CLS_CALC, CLS_COPY, CLS_COND.
  - Constants IO_REG = 6, RF_MUX_* encodings.
  - Condition code constants.
- Sub-module overture_cond_eval: combinational (cond[2:0], val[7:0]) → taken.

Test Plan:
- Reset release, run = 1, ack 2 cycles after req with data 0x05 → imem_addr = 0x00. Then one EXEC cycle: rf_wr_en = 1, rf_dst = 0, rf_mux = 0, imm_data = 0x05, retired = 1. Next fetch at 0x01.
- Conditions with reg0_val = 0x20:
  - 0xC4 → next fetch 0x20.
  - 0xC1 with reg3 = 0x00 → 0x20; with reg3 = 0x01 → pc + 1.
  - 0xC2 with reg3 = 0x80 → 0x20.
  - 0xC7 with reg3 = 0x00 → pc + 1.
  - rf_wr_en stays 0 throughout.
- Copy 0xB1 (src 6 → dst 1), io_in_valid low 3 cycles → io_in_ready = 1 with no retire and no write for 3 cycles. Valid on cycle 4 → rf_wr_en = 1, rf_dst = 1, retired = 1.
- Copy 0xB6 (6 → 6), io_in_valid = 1, io_out_ready = 0 → io_out_valid = 1, io_in_ready = 0, stall. io_out_ready = 1 → both handshakes complete the same cycle, retire, no rf write.
- Immediate 0x3F at PC 0xFF → imm_data = 0x3F, next imem_addr = 0x00.
- run dropped during FETCH → fetch and EXEC still complete, then IDLE with imem_req = 0. Async rst low during a copy stall → all outputs go to reset values before the next clk edge.
